// File: rtl/bp_pkg.sv
// Shared branch-resolution types and the mispredict/correct-PC rule.
// Also used by the predictor bench model, so the compare rule lives here and nowhere else.
// Contents: pred_rec_t (queued prediction), resolve_t (compare result), resolve_branch().
package bp_pkg;

  localparam int AW         = 32;
  localparam int INSN_BYTES = 4;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          taken;
    logic [AW-1:0] target;
    logic          hit;
  } pred_rec_t;

  typedef struct packed {
    logic          mispredict;
    logic [AW-1:0] correct_pc;
  } resolve_t;

  // A taken/taken pair only counts as correct if the targets also agree.
  // The fall-through add wraps at AW bits by construction.
  function automatic resolve_t resolve_branch(input pred_rec_t     head,
                                              input logic          res_taken,
                                              input logic [AW-1:0] res_target);
    resolve_t r;
    r.mispredict = (head.taken != res_taken) |
                   (res_taken & head.taken & (head.target != res_target));
    r.correct_pc = res_taken ? res_target : head.pc + AW'(INSN_BYTES);
    return r;
  endfunction

endpackage

// File: rtl/br_fifo.sv
// In-flight prediction queue: synchronous FIFO of pred_rec_t with synchronous clear.
// Latency: a pushed record is visible at head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; clear beats push and pop.
// Ports: clk, rst (async active-low), push/wr_dat, pop, clear, head, full, empty.
module br_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  pred_rec_t wr_dat,
  input  logic      pop,
  input  logic      clear,
  output pred_rec_t head,
  output logic      full,
  output logic      empty
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  pred_rec_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset: nothing reads it until count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/br_resolve.sv
// In-order branch resolution: compares queued predictions with execute outcomes, emits redirect + BTB training.
// Latency: 1 cycle from res handshake to registered redirect/train pulses and counter update.
// Backpressure: pred_ready drops when the queue is full or during the redirect cycle; res_ready only when non-empty.
// Ports: clk, rst (async active-low); pred_* push side; res_* resolve side; redirect_*, train_* pulses; counters.
// Address width and fall-through increment come from bp_pkg (AW, INSN_BYTES).
module br_resolve
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pred_valid,
  output logic          pred_ready,
  input  logic [AW-1:0] pred_pc,
  input  logic          pred_taken,
  input  logic [AW-1:0] pred_target,
  input  logic          pred_hit,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic          res_taken,
  input  logic [AW-1:0] res_target,
  output logic          redirect_valid,
  output logic [AW-1:0] redirect_pc,
  output logic          train_valid,
  output logic [AW-1:0] train_pc,
  output logic [AW-1:0] train_target,
  output logic          train_taken,
  output logic          train_alloc,
  output logic [31:0]   branch_count,
  output logic [31:0]   mispred_count
);

  pred_rec_t wr_rec;
  pred_rec_t head;
  resolve_t  res;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      flush;

  // Gating with rst keeps pred_ready low while reset is held (all outputs 0).
  // Refusing pushes during the redirect cycle stops wrong-path fetch records.
  assign pred_ready = rst & ~full & ~redirect_valid;
  assign res_ready  = ~empty;
  assign push       = pred_valid & pred_ready;
  assign pop        = res_valid & res_ready;

  assign wr_rec = '{pc: pred_pc, taken: pred_taken, target: pred_target, hit: pred_hit};
  assign res    = resolve_branch(head, res_taken, res_target);

  // Every younger entry is wrong-path once the head mispredicts; a same-cycle push is dropped too.
  assign flush  = pop & res.mispredict;

  br_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_dat (wr_rec),
    .pop    (pop),
    .clear  (flush),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      train_valid    <= 1'b0;
      train_pc       <= '0;
      train_target   <= '0;
      train_taken    <= 1'b0;
      train_alloc    <= 1'b0;
      branch_count   <= '0;
      mispred_count  <= '0;
    end else begin
      redirect_valid <= pop & res.mispredict;
      train_valid    <= pop & (head.hit | res_taken);
      if (pop) begin
        redirect_pc   <= res.correct_pc;
        train_pc      <= head.pc;
        train_target  <= res_target;
        train_taken   <= res_taken;
        train_alloc   <= ~head.hit & res_taken;
        branch_count  <= branch_count + 32'd1;
        mispred_count <= mispred_count + 32'(res.mispredict);
      end
    end
  end

endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve: table of single push/resolve vectors plus hand sequences
// for reset, flush, full queue, empty-resolve and mid-stream reset.
module tb_br_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_ready;
  logic [31:0] pred_pc, pred_target;
  logic        pred_taken, pred_hit;
  logic        res_valid, res_ready, res_taken;
  logic [31:0] res_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        train_valid, train_taken, train_alloc;
  logic [31:0] train_pc, train_target;
  logic [31:0] branch_count, mispred_count;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_mis = 0;

  always #5 clk = ~clk;

  br_resolve #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken), .res_target(res_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .train_valid(train_valid), .train_pc(train_pc), .train_target(train_target),
    .train_taken(train_taken), .train_alloc(train_alloc),
    .branch_count(branch_count), .mispred_count(mispred_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_pred(input logic v, input logic [31:0] pc, input logic t,
                          input logic [31:0] tgt, input logic h);
    pred_valid = v; pred_pc = pc; pred_taken = t; pred_target = tgt; pred_hit = h;
  endtask

  task automatic set_res(input logic v, input logic t, input logic [31:0] tgt);
    res_valid = v; res_taken = t; res_target = tgt;
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".branch_count"}, 64'(branch_count), 64'(exp_br));
    check({tag, ".mispred_count"}, 64'(mispred_count), 64'(exp_mis));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pred_ready"}, 64'(pred_ready), 64'd0);
    check({tag, ".res_ready"}, 64'(res_ready), 64'd0);
    check({tag, ".redirect_valid"}, 64'(redirect_valid), 64'd0);
    check({tag, ".redirect_pc"}, 64'(redirect_pc), 64'd0);
    check({tag, ".train_valid"}, 64'(train_valid), 64'd0);
    check({tag, ".train_pc"}, 64'(train_pc), 64'd0);
    check({tag, ".train_target"}, 64'(train_target), 64'd0);
    check({tag, ".train_taken"}, 64'(train_taken), 64'd0);
    check({tag, ".train_alloc"}, 64'(train_alloc), 64'd0);
    check({tag, ".branch_count"}, 64'(branch_count), 64'd0);
    check({tag, ".mispred_count"}, 64'(mispred_count), 64'd0);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        ph;
    logic        rt;
    logic [31:0] rtgt;
    logic        e_tv;
    logic        e_tt;
    logic        e_ta;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    //          pc            pt    ptgt          ph    rt    rtgt          tv    tt    ta    rv    rpc
    vecs[0] = '{32'h100,      1'b1, 32'h200,      1'b1, 1'b1, 32'h200,      1'b1, 1'b1, 1'b0, 1'b0, 32'h200};
    vecs[1] = '{32'h104,      1'b0, 32'h0,        1'b0, 1'b1, 32'h300,      1'b1, 1'b1, 1'b1, 1'b1, 32'h300};
    vecs[2] = '{32'h480,      1'b1, 32'h500,      1'b1, 1'b1, 32'h504,      1'b1, 1'b1, 1'b0, 1'b1, 32'h504};
    vecs[3] = '{32'hFFFFFFFC, 1'b1, 32'h1000,     1'b1, 1'b0, 32'hDEAD,     1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{32'h200,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h204};
    vecs[5] = '{32'h300,      1'b0, 32'h0,        1'b1, 1'b0, 32'h999,      1'b1, 1'b0, 1'b0, 1'b0, 32'h304};
    vecs[6] = '{32'h400,      1'b1, 32'h800,      1'b0, 1'b1, 32'h800,      1'b1, 1'b1, 1'b1, 1'b0, 32'h800};

    // ---- reset state ----
    rst = 1'b0;
    set_pred(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    set_res(1'b0, 1'b0, 32'h0);
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_reset.pred_ready", 64'(pred_ready), 64'd1);
    check("post_reset.res_ready", 64'(res_ready), 64'd0);
    @(negedge clk);

    // ---- table vectors: push one record, resolve it, check, idle one cycle ----
    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      set_pred(1'b1, vecs[i].pc, vecs[i].pt, vecs[i].ptgt, vecs[i].ph);
      step();
      set_pred(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check({tag, ".res_ready"}, 64'(res_ready), 64'd1);
      set_res(1'b1, vecs[i].rt, vecs[i].rtgt);
      step();
      set_res(1'b0, 1'b0, 32'h0);
      exp_br  = exp_br + 1;
      exp_mis = exp_mis + 32'(vecs[i].e_rv);
      check({tag, ".train_valid"}, 64'(train_valid), 64'(vecs[i].e_tv));
      check({tag, ".train_taken"}, 64'(train_taken), 64'(vecs[i].e_tt));
      check({tag, ".train_alloc"}, 64'(train_alloc), 64'(vecs[i].e_ta));
      check({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(vecs[i].e_rv));
      check({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(vecs[i].e_rpc));
      check({tag, ".train_pc"}, 64'(train_pc), 64'(vecs[i].pc));
      check({tag, ".train_target"}, 64'(train_target), 64'(vecs[i].rtgt));
      check_counters(tag);
      step();
      check({tag, ".idle_train_valid"}, 64'(train_valid), 64'd0);
      check({tag, ".idle_redirect_valid"}, 64'(redirect_valid), 64'd0);
      check({tag, ".hold_redirect_pc"}, 64'(redirect_pc), 64'(vecs[i].e_rpc));
      check({tag, ".res_ready_empty"}, 64'(res_ready), 64'd0);
    end

    // ---- flush: head mispredicts with 3 younger entries and a simultaneous push ----
    set_pred(1'b1, 32'h108, 1'b1, 32'h400, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      set_pred(1'b1, 32'h10C + 32'(4 * i), 1'b0, 32'h0, 1'b0);
      step();
    end
    set_pred(1'b1, 32'h999, 1'b0, 32'h0, 1'b0);
    set_res(1'b1, 1'b0, 32'h0);
    step();
    set_res(1'b0, 1'b0, 32'h0);
    exp_br  = exp_br + 1;
    exp_mis = exp_mis + 1;
    check("flush.redirect_valid", 64'(redirect_valid), 64'd1);
    check("flush.redirect_pc", 64'(redirect_pc), 64'h10C);
    check("flush.res_ready", 64'(res_ready), 64'd0);
    check("flush.pred_ready_redirect", 64'(pred_ready), 64'd0);
    check_counters("flush");
    step();  // pred_valid still high: must be refused
    check("flush.pred_ready_after", 64'(pred_ready), 64'd1);
    check("flush.res_ready_after", 64'(res_ready), 64'd0);
    check("flush.redirect_cleared", 64'(redirect_valid), 64'd0);
    set_pred(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // ---- full queue, refused 9th push, push+pop at occupancy 4 ----
    for (int i = 0; i < 8; i++) begin
      set_pred(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 32'h0, 1'b0);
      step();
    end
    check("full.pred_ready", 64'(pred_ready), 64'd0);
    set_pred(1'b1, 32'hBAD0, 1'b0, 32'h0, 1'b0);
    step();
    check("full.pred_ready_hold", 64'(pred_ready), 64'd0);
    set_res(1'b1, 1'b0, 32'h0);  // pop while 9th push still offered
    step();
    set_pred(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    set_res(1'b0, 1'b0, 32'h0);
    exp_br = exp_br + 1;
    check("full.pred_ready_after_pop", 64'(pred_ready), 64'd1);
    check("full.pop_train_pc", 64'(train_pc), 64'h1000);
    set_res(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step();
    exp_br = exp_br + 3;
    check("occ4.train_pc", 64'(train_pc), 64'h100C);
    set_pred(1'b1, 32'h2000, 1'b0, 32'h0, 1'b0);
    step();  // simultaneous push + pop
    set_pred(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    exp_br = exp_br + 1;
    check("occ4.pushpop_train_pc", 64'(train_pc), 64'h1010);
    begin
      int drained;
      drained = 0;
      for (int i = 0; i < 10; i++) begin
        if (res_ready) drained++;
        step();
      end
      set_res(1'b0, 1'b0, 32'h0);
      check("occ4.drain_count", 64'(drained), 64'd4);
      exp_br = exp_br + 4;
    end
    check("occ4.last_train_pc", 64'(train_pc), 64'h2000);
    check_counters("occ4");

    // ---- resolve offered while empty ----
    set_res(1'b1, 1'b1, 32'h1234);
    step();
    check("empty_res.train_valid", 64'(train_valid), 64'd0);
    check("empty_res.redirect_valid", 64'(redirect_valid), 64'd0);
    step();
    set_res(1'b0, 1'b0, 32'h0);
    check_counters("empty_res");
    check("empty_res.train_pc_held", 64'(train_pc), 64'h2000);

    // ---- async reset mid-stream with a pending train pulse ----
    for (int i = 0; i < 4; i++) begin
      set_pred(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 32'h3100, 1'b1);
      step();
    end
    set_pred(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    set_res(1'b1, 1'b1, 32'h3100);
    step();
    check("midrst.pre_train_valid", 64'(train_valid), 64'd1);
    check("midrst.pre_res_ready", 64'(res_ready), 64'd1);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    check_all_zero("midrst_hold");
    rst = 1'b1;
    #1;
    check("midrst.release_res_ready", 64'(res_ready), 64'd0);
    check("midrst.release_pred_ready", 64'(pred_ready), 64'd1);
    step();
    set_res(1'b0, 1'b0, 32'h0);
    check("midrst.after_train_valid", 64'(train_valid), 64'd0);
    check("midrst.after_redirect_valid", 64'(redirect_valid), 64'd0);
    check("midrst.after_branch_count", 64'(branch_count), 64'd0);
    check("midrst.after_mispred_count", 64'(mispred_count), 64'd0);
    check("midrst.after_res_ready", 64'(res_ready), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/br_resolve.md
Name: br_resolve

Overview:
- In-order branch resolution unit; the consumer/training end of the branch predictor.
- Fetch pushes one prediction record per predicted branch into an in-flight queue. Execute resolves branches in program order.
- For each resolution the block compares prediction against outcome, then emits a redirect on mispredict and a training write back to the BTB.
- Sits between the fetch/predictor stage and execute; its train outputs drive the predictor's train/update interface.

Parameters:
- DEPTH, 8, in-flight prediction queue entries (power of 2, >=2)
- AW, 32, address width
- INSN_BYTES, 4, fall-through increment for a not-taken redirect

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- pred_valid  in  1  fetch offers a prediction record
- pred_ready  out  1  record accepted when pred_valid & pred_ready
- pred_pc  in  AW  branch PC
- pred_taken  in  1  predicted direction
- pred_target  in  AW  predicted target (don't-care when not taken)
- pred_hit  in  1  BTB hit at prediction time
- res_valid  in  1  execute offers the outcome of the oldest unresolved branch
- res_ready  out  1  outcome accepted when res_valid & res_ready
- res_taken  in  1  actual direction
- res_target  in  AW  actual target
- redirect_valid  out  1  one-cycle pulse; fetch must restart at redirect_pc
- redirect_pc  out  AW  correct next PC
- train_valid  out  1  one-cycle pulse; BTB update request
- train_pc  out  AW  PC to update
- train_target  out  AW  target to write
- train_taken  out  1  counter direction (1 = increment, 0 = decrement)
- train_alloc  out  1  allocate a new BTB entry (miss and taken)
- branch_count  out  32  accepted resolutions, wraps
- mispred_count  out  32  mispredicts, wraps

Behaviour:
- Reset (rst low, async): queue empty; all outputs 0; counters 0. pred_ready reads 1 and res_ready reads 0 immediately after reset release.
- Queue:
  - FIFO of {pc, taken, target, hit}.
  - pred_ready = !full & !redirect_valid.
  - res_ready = !empty.
  - Push and pop in the same cycle are both honoured when not full/empty. When full, pred_ready=0 even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH; occupancy count is log2(DEPTH)+1 bits.
- Resolution, on res handshake, evaluated against the head record:
  - mispredict = (head.taken != res_taken) | (res_taken & head.taken & head.target != res_target).
  - correct_pc = res_taken ? res_target : head.pc + INSN_BYTES, truncated to AW bits (wraps).
- Outputs are registered, so latency is 1 cycle: on the edge after the handshake,
  - train_valid = head.hit | res_taken
  - train_pc = head.pc, train_target = res_target, train_taken = res_taken
  - train_alloc = !head.hit & res_taken
  - redirect_valid = mispredict, redirect_pc = correct_pc
  - branch_count += 1; mispred_count += mispredict
  - Without a handshake, train_valid and redirect_valid return to 0 next cycle; the pc/target outputs hold their last value.
- Flush:
  - On a mispredicting handshake, the queue clears at that same edge; all younger entries are wrong-path.
  - A push in that same cycle is discarded.
  - During the following cycle (redirect_valid=1), pred_ready=0, so pushes from the still-wrong-path fetch are refused.
  - Normal acceptance resumes the cycle after.
- res_valid while empty: ignored, no output pulse, counters unchanged.
- Counters wrap from 0xFFFF_FFFF to 0.
- Async reset mid-operation: queue and pending pulses are dropped immediately; no partial train/redirect is emitted after release.

Decomposition:
- Package bp_pkg holds:
  - typedef struct packed pred_rec_t {pc, taken, target, hit}
  - localparams INSN_BYTES, AW
  - A function computing mispredict/correct_pc, shared with the predictor bench model.
- One sub-module, br_fifo: parameterised synchronous FIFO of pred_rec_t with a synchronous clear input, full/empty flags, and the same asynchronous active-low reset.
- br_resolve instantiates br_fifo and adds the compare logic, output registers and counters.

Test Plan:
1. Push {pc=0x100, taken=1, target=0x200, hit=1}, then resolve taken/0x200 -> next cycle train_valid=1, train_taken=1, train_alloc=0, redirect_valid=0, branch_count=1, mispred_count=0.
2. Push {pc=0x104, taken=0, hit=0}, resolve taken/0x300 -> redirect_valid=1, redirect_pc=0x300, train_alloc=1, mispred_count=1.
3. Push {pc=0x108, taken=1, target=0x400, hit=1} plus 3 younger records, resolve not-taken for 0x108 with a simultaneous push -> redirect_pc=0x10C, queue empty afterwards (res_ready=0), pred_ready=0 during the redirect cycle, then 1.
4. Fill DEPTH=8 records -> pred_ready=0 and a 9th push is refused; one pop -> pred_ready=1 next cycle; push+pop at occupancy 4 keeps occupancy at 4.
5. Wrong target: predicted taken 0x500, actual taken 0x504 -> mispredict, redirect_pc=0x504, train_target=0x504; pred_pc=0xFFFF_FFFC resolved not-taken after a taken prediction -> redirect_pc=0x0.
6. Assert rst mid-stream with 3 queued entries and res_valid=1 -> all outputs 0 during reset; after release res_ready=0, counters 0, no train/redirect pulse.
